// File: rtl/kg_frame_patch.sv
// kg_frame_patch
//   Byte-rewrite stage for the 512-bit CMAC-side AXI-Stream path. Overwrites a
//   single byte at an absolute byte offset anywhere inside a frame. The patch
//   configuration is captured on the first beat of every frame, so a frame
//   never sees mixed settings. The output is registered and backed by a
//   one-entry skid buffer, which gives full throughput under backpressure.
//
// Optional feature (compile-time macro KG_FRAME_PATCH_MASK_EN):
//   Adds the cfg_mask port. The patched byte becomes (in & ~mask) | (data & mask).
//   Without the macro the whole byte is replaced.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   cfg_enable          patch enable, captured at frame start
//   cfg_offset          absolute byte offset of the patch within the frame
//   cfg_data            replacement byte
//   cfg_mask            (KG_FRAME_PATCH_MASK_EN only) bit-select mask for the patch
//   s_axis_*            input stream (tdata/tkeep/tvalid/tready/tlast/tuser)
//   m_axis_*            output stream, one cycle behind input acceptance
//   stat_frames         frames completed (input tlast accepted)
//   stat_patched        frames in which the patch byte was written
//   stat_short          enabled frames that ended before the patch byte was reached

module kg_frame_patch #(
    parameter int DATA_WIDTH   = 512,
    parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int USER_WIDTH   = 1,
    parameter int OFFSET_WIDTH = 16,
    parameter int STAT_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_enable,
    input  logic [OFFSET_WIDTH-1:0] cfg_offset,
    input  logic [7:0]              cfg_data,
`ifdef KG_FRAME_PATCH_MASK_EN
    input  logic [7:0]              cfg_mask,
`endif
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic [USER_WIDTH-1:0]   s_axis_tuser,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [USER_WIDTH-1:0]   m_axis_tuser,
    output logic [STAT_WIDTH-1:0]   stat_frames,
    output logic [STAT_WIDTH-1:0]   stat_patched,
    output logic [STAT_WIDTH-1:0]   stat_short
);

    localparam int BEAT_W = OFFSET_WIDTH - 6;

    if (DATA_WIDTH != 512 || KEEP_WIDTH * 8 != DATA_WIDTH || OFFSET_WIDTH <= 6) begin : g_bad_params
        $error("kg_frame_patch: DATA_WIDTH must be 512, KEEP_WIDTH*8 == DATA_WIDTH, OFFSET_WIDTH > 6");
    end

    typedef enum logic {ST_IDLE, ST_FRAME} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_WIDTH-1:0] keep;
        logic                  last;
        logic [USER_WIDTH-1:0] user;
    } beat_t;

    state_t                  r_state;
    logic [BEAT_W-1:0]       r_beat_idx;   // index of the next beat to arrive in FRAME
    logic                    r_done;       // patch already applied in this frame
    logic                    r_sh_en;
    logic [OFFSET_WIDTH-1:0] r_sh_off;
    logic [7:0]              r_sh_data;
`ifdef KG_FRAME_PATCH_MASK_EN
    logic [7:0]              r_sh_mask;
`endif

    logic                    r_s_ready;
    logic                    r_m_valid;
    logic                    r_sk_valid;
    beat_t                   r_out;
    beat_t                   r_skid;

    logic [STAT_WIDTH-1:0]   r_frames;
    logic [STAT_WIDTH-1:0]   r_patched;
    logic [STAT_WIDTH-1:0]   r_short;

    logic                    w_first;
    logic                    w_en;
    logic [OFFSET_WIDTH-1:0] w_off;
    logic [7:0]              w_dat;
    logic [7:0]              w_msk;
    logic [BEAT_W-1:0]       w_idx;
    logic                    w_done;
    logic [5:0]              w_lane;
    logic                    w_in_acc;
    logic                    w_hit;
    logic [7:0]              w_orig_byte;
    logic [7:0]              w_new_byte;
    beat_t                   w_beat;
    logic                    w_m_free;
    logic                    w_sk_next;

    // On the first beat the live config is used directly; the same values are
    // captured into the shadow registers for the rest of the frame.
    assign w_first  = (r_state == ST_IDLE);
    assign w_en     = w_first ? cfg_enable : r_sh_en;
    assign w_off    = w_first ? cfg_offset : r_sh_off;
    assign w_dat    = w_first ? cfg_data   : r_sh_data;
`ifdef KG_FRAME_PATCH_MASK_EN
    assign w_msk    = w_first ? cfg_mask   : r_sh_mask;
`else
    assign w_msk    = 8'hff;
`endif
    assign w_idx    = w_first ? '0 : r_beat_idx;
    assign w_done   = !w_first && r_done;
    assign w_lane   = w_off[5:0];
    assign w_in_acc = s_axis_tvalid && r_s_ready;

    // The done flag keeps a saturated beat counter from patching twice.
    assign w_hit = w_in_acc && w_en && !w_done
                && (w_idx == w_off[OFFSET_WIDTH-1:6]) && s_axis_tkeep[w_lane];

    assign w_orig_byte = s_axis_tdata[{w_lane, 3'b000} +: 8];
    assign w_new_byte  = (w_orig_byte & ~w_msk) | (w_dat & w_msk);

    // NOTE: every output of a combinational block gets a default before any
    // conditional override, otherwise synthesis infers a latch.
    always_comb begin
        w_beat.data = s_axis_tdata;
        w_beat.keep = s_axis_tkeep;
        w_beat.last = s_axis_tlast;
        w_beat.user = s_axis_tuser;
        if (w_hit) begin
            w_beat.data[{w_lane, 3'b000} +: 8] = w_new_byte;
        end
    end

    // Frame tracking FSM: shadow config, beat index and done flag.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_beat_idx <= '0;
            r_done     <= 1'b0;
            r_sh_en    <= 1'b0;
            r_sh_off   <= '0;
            r_sh_data  <= '0;
`ifdef KG_FRAME_PATCH_MASK_EN
            r_sh_mask  <= '0;
`endif
        end else if (w_in_acc) begin
            r_done  <= w_done || w_hit;
            r_state <= s_axis_tlast ? ST_IDLE : ST_FRAME;
            if (w_first) begin
                r_sh_en    <= cfg_enable;
                r_sh_off   <= cfg_offset;
                r_sh_data  <= cfg_data;
`ifdef KG_FRAME_PATCH_MASK_EN
                r_sh_mask  <= cfg_mask;
`endif
                r_beat_idx <= BEAT_W'(1);
            end else if (r_beat_idx != '1) begin
                r_beat_idx <= r_beat_idx + BEAT_W'(1);
            end
        end
    end

    // Output register + one-entry skid buffer. Ready is registered, so a beat
    // may arrive in the cycle the output stalls; the skid entry absorbs it.
    assign w_m_free  = !r_m_valid || m_axis_tready;
    assign w_sk_next = !w_m_free && (r_sk_valid || w_in_acc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_valid  <= 1'b0;
            r_sk_valid <= 1'b0;
            r_s_ready  <= 1'b0;
        end else begin
            if (w_m_free) begin
                r_m_valid <= r_sk_valid || w_in_acc;
            end
            r_sk_valid <= w_sk_next;
            r_s_ready  <= !w_sk_next;
        end
    end

    // NOTE: the payload registers are not reset; the valid flags above
    // qualify them, and leaving wide data out of reset saves routing.
    always_ff @(posedge clk) begin
        if (w_m_free) begin
            if (r_sk_valid) begin
                r_out <= r_skid;
            end else if (w_in_acc) begin
                r_out <= w_beat;
            end
        end else if (w_in_acc) begin
            r_skid <= w_beat;
        end
    end

    // Statistics, updated on input acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frames  <= '0;
            r_patched <= '0;
            r_short   <= '0;
        end else if (w_in_acc) begin
            if (w_hit) begin
                r_patched <= r_patched + STAT_WIDTH'(1);
            end
            if (s_axis_tlast) begin
                r_frames <= r_frames + STAT_WIDTH'(1);
                if (w_en && !w_done && !w_hit) begin
                    r_short <= r_short + STAT_WIDTH'(1);
                end
            end
        end
    end

    assign s_axis_tready = r_s_ready;
    assign m_axis_tvalid = r_m_valid;
    assign m_axis_tdata  = r_out.data;
    assign m_axis_tkeep  = r_out.keep;
    assign m_axis_tlast  = r_out.last;
    assign m_axis_tuser  = r_out.user;
    assign stat_frames   = r_frames;
    assign stat_patched  = r_patched;
    assign stat_short    = r_short;

endmodule

// File: tb/tb_kg_frame_patch.sv
// Testbench for kg_frame_patch: directed frames plus a randomly stalled
// back-to-back run. The driver pushes each accepted beat's expected output
// into a scoreboard queue; an independent monitor pops and compares every beat
// the DUT presents, and also checks output stability while stalled.

module tb_kg_frame_patch;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_enable = 1'b0;
    logic [15:0]  cfg_offset = '0;
    logic [7:0]   cfg_data = '0;
`ifdef KG_FRAME_PATCH_MASK_EN
    logic [7:0]   cfg_mask = 8'hff;
`endif
    logic [511:0] s_axis_tdata = '0;
    logic [63:0]  s_axis_tkeep = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tready;
    logic         s_axis_tlast = 1'b0;
    logic [0:0]   s_axis_tuser = '0;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b1;
    logic         m_axis_tlast;
    logic [0:0]   m_axis_tuser;
    logic [31:0]  stat_frames;
    logic [31:0]  stat_patched;
    logic [31:0]  stat_short;

    kg_frame_patch dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_enable    (cfg_enable),
        .cfg_offset    (cfg_offset),
        .cfg_data      (cfg_data),
`ifdef KG_FRAME_PATCH_MASK_EN
        .cfg_mask      (cfg_mask),
`endif
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .stat_frames   (stat_frames),
        .stat_patched  (stat_patched),
        .stat_short    (stat_short)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] d;
        logic [63:0]  k;
        logic         l;
        logic [0:0]   u;
        int           cyc;
        bit           lat;
    } exp_t;

    exp_t         sb[$];
    logic [511:0] out_log[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           m_frames = 0;
    int           m_patched = 0;
    int           m_short = 0;
    bit           rand_rdy = 1'b0;
    bit           fixed_rdy = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Output ready generator, updated shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        m_axis_tready = rand_rdy ? 1'($urandom_range(1)) : fixed_rdy;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard comparison and stall-stability checks.
    bit           prev_stall = 1'b0;
    logic [577:0] prev_bus;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_cmp++;
                if (!m_axis_tvalid || {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} !== prev_bus) begin
                    n_err++;
                    $display("FAIL stall_stable: valid=%0b bus changed while stalled", m_axis_tvalid);
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_bus   = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
            if (m_axis_tvalid && m_axis_tready) begin
                out_log.push_back(m_axis_tdata);
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_beat: got data %h with empty scoreboard", m_axis_tdata);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} !== {e.d, e.k, e.l, e.u}) begin
                        n_err++;
                        $display("FAIL beat: got d=%h k=%h l=%0b u=%0b expected d=%h k=%h l=%0b u=%0b",
                                 m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, e.d, e.k, e.l, e.u);
                    end
                    if (e.lat) begin
                        n_cmp++;
                        if (cyc - e.cyc != 1) begin
                            n_err++;
                            $display("FAIL latency: got %0d expected 1", cyc - e.cyc);
                        end
                    end
                end
            end
        end
    end

    // Drives one frame; the expected output of every accepted beat is pushed
    // into the scoreboard. Model: config is taken from the values set at
    // frame start; the patch lands on beat off/64, lane off%64, if kept.
    task automatic send_frame(input int nb, input bit en, input logic [15:0] off,
                              input logic [7:0] dat, input logic [7:0] msk,
                              input logic [63:0] lkeep, input bit det, input bit lat,
                              input bit mid, input logic [7:0] mid_dat, input bit scr);
        logic [7:0]   emsk;
        logic [511:0] d;
        logic [63:0]  k;
        logic [7:0]   ob;
        bit           hit_seen;
        bit           acc;
        int           tmo;
        exp_t         e;
        hit_seen   = 1'b0;
        cfg_enable = en;
        cfg_offset = off;
        cfg_data   = dat;
`ifdef KG_FRAME_PATCH_MASK_EN
        cfg_mask   = msk;
        emsk       = msk;
`else
        emsk       = 8'hff;
`endif
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < 64; j++) begin
                d[j*8 +: 8] = det ? 8'(b * 64 + j) : 8'($urandom);
            end
            k = (b == nb - 1) ? lkeep : '1;
            s_axis_tdata  = d;
            s_axis_tkeep  = k;
            s_axis_tlast  = (b == nb - 1);
            s_axis_tuser  = 1'($urandom_range(1));
            s_axis_tvalid = 1'b1;
            acc = 1'b0;
            tmo = 0;
            while (!acc && tmo < 500) begin
                @(negedge clk);
                if (s_axis_tready) begin
                    acc = 1'b1;
                    e.d = d; e.k = k; e.l = s_axis_tlast; e.u = s_axis_tuser;
                    e.cyc = cyc; e.lat = lat;
                    if (en && b == int'(off[15:6]) && k[off[5:0]]) begin
                        ob = d[{off[5:0], 3'b000} +: 8];
                        e.d[{off[5:0], 3'b000} +: 8] = (ob & ~emsk) | (dat & emsk);
                        hit_seen = 1'b1;
                        m_patched++;
                    end
                    sb.push_back(e);
                end
                @(posedge clk);
                #1;
                tmo++;
            end
            if (!acc) begin
                n_cmp++;
                n_err++;
                $display("FAIL accept_timeout: beat %0d not accepted", b);
            end
            if (b == 0) begin
                if (mid) cfg_data = mid_dat;
                if (scr) begin
                    cfg_enable = 1'($urandom_range(1));
                    cfg_offset = 16'($urandom);
                    cfg_data   = 8'($urandom);
`ifdef KG_FRAME_PATCH_MASK_EN
                    cfg_mask   = 8'($urandom);
`endif
                end
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_frames++;
        if (en && !hit_seen) m_short++;
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while (sb.size() != 0 && i < 3000) begin
            @(posedge clk);
            i++;
        end
        #1;
        check({name, "_drained"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic check_stats(input string name);
        check({name, "_frames"},  64'(stat_frames),  64'(m_frames));
        check({name, "_patched"}, 64'(stat_patched), 64'(m_patched));
        check({name, "_short"},   64'(stat_short),   64'(m_short));
    endtask

    initial begin
        logic [511:0] t;
        int acc_n;
        int tmo;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_m_valid", 64'(m_axis_tvalid), 64'd0);
        check("rst_s_ready", 64'(s_axis_tready), 64'd0);
        check("rst_frames",  64'(stat_frames),   64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_s_ready", 64'(s_axis_tready), 64'd1);
        @(posedge clk);
        #1;

        // 3-beat frame, offset 70 -> beat 1 lane 6 = 5a, latency 1
        out_log.delete();
        send_frame(3, 1'b1, 16'd70, 8'h5a, 8'hff, '1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        drain("t1");
        check("t1_nbeats", 64'(out_log.size()), 64'd3);
        t = out_log[1];
        check("t1_byte6", 64'(t[6*8 +: 8]), 64'h5a);
        t = out_log[1];
        check("t1_byte7", 64'(t[7*8 +: 8]), 64'h47);
        check("t1_frames",  64'(stat_frames),  64'd1);
        check("t1_patched", 64'(stat_patched), 64'd1);

        // 1-beat frame, keep covers lanes 0..15, offset 20 -> short, unmodified
        out_log.delete();
        send_frame(1, 1'b1, 16'd20, 8'haa, 8'hff, 64'h0000_0000_0000_ffff, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        drain("t2");
        t = out_log[0];
        check("t2_byte20", 64'(t[20*8 +: 8]), 64'h14);
        check("t2_short",   64'(stat_short),   64'd1);
        check("t2_patched", 64'(stat_patched), 64'd1);
        check("t2_frames",  64'(stat_frames),  64'd2);

        // Mid-frame cfg_data change only affects the next frame
        out_log.delete();
        send_frame(4, 1'b1, 16'd200, 8'h11, 8'hff, '1, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0);
        send_frame(4, 1'b1, 16'd200, 8'h22, 8'hff, '1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        drain("t3");
        t = out_log[3];
        check("t3_frameA_b3l8", 64'(t[8*8 +: 8]), 64'h11);
        t = out_log[7];
        check("t3_frameB_b3l8", 64'(t[8*8 +: 8]), 64'h22);
        check_stats("t3");

`ifdef KG_FRAME_PATCH_MASK_EN
        // Masked patch: input f0 (beat 3 lane 48), data 0f, mask 3c -> cc
        out_log.delete();
        send_frame(4, 1'b1, 16'd240, 8'h0f, 8'h3c, '1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        drain("tm");
        t = out_log[3];
        check("tm_masked_byte", 64'(t[48*8 +: 8]), 64'hcc);
`endif

        // 100 back-to-back frames, random output ready, config scrambled mid-frame
        rand_rdy = 1'b1;
        for (int f = 0; f < 100; f++) begin
            int nb;
            nb = $urandom_range(1, 6);
            send_frame(nb, ($urandom_range(3) != 0), 16'($urandom_range(nb * 64 + 80)),
                       8'($urandom), 8'($urandom), {$urandom, $urandom} | 64'h1,
                       1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        end
        rand_rdy = 1'b0;
        fixed_rdy = 1'b1;
        drain("rnd");
        check_stats("rnd");

        // Reset with the skid buffer full
        fixed_rdy = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        cfg_enable = 1'b1;
        cfg_offset = 16'd3;
        cfg_data   = 8'h77;
        s_axis_tkeep  = '1;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        acc_n = 0;
        tmo = 0;
        while (acc_n < 2 && tmo < 50) begin
            s_axis_tdata = {16{$urandom}};
            @(negedge clk);
            if (s_axis_tready) acc_n++;
            @(posedge clk);
            #1;
            tmo++;
        end
        @(negedge clk);
        check("full_s_ready", 64'(s_axis_tready), 64'd0);
        check("full_m_valid", 64'(m_axis_tvalid), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_m_valid", 64'(m_axis_tvalid), 64'd0);
        check("arst_s_ready", 64'(s_axis_tready), 64'd0);
        check("arst_frames",  64'(stat_frames),   64'd0);
        check("arst_patched", 64'(stat_patched),  64'd0);
        check("arst_short",   64'(stat_short),    64'd0);
        s_axis_tvalid = 1'b0;
        sb.delete();
        m_frames = 0;
        m_patched = 0;
        m_short = 0;
        fixed_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rel2_s_ready", 64'(s_axis_tready), 64'd1);
        @(posedge clk);
        #1;

        // Frame after reset is handled from a clean state
        out_log.delete();
        send_frame(3, 1'b1, 16'd70, 8'h5a, 8'hff, '1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        drain("post");
        check("post_nbeats", 64'(out_log.size()), 64'd3);
        t = out_log[1];
        check("post_byte6", 64'(t[6*8 +: 8]), 64'h5a);
        check_stats("post");

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/kg_frame_patch.md
Name: kg_frame_patch

Overview:
- Byte-rewrite stage on the 512-bit CMAC-side AXI-Stream path, directly downstream of the per-port register-driven offload stage, directly upstream of the CMAC TX interface.
- Overwrites one byte at a configurable absolute offset anywhere in a frame, not just in beat 0.
- Latches configuration at frame start, so a frame is never patched with mixed settings.
- Registered output with skid buffer gives full throughput and correct backpressure; frame, patch and short-frame statistics counters are kept.

Parameters:
- DATA_WIDTH, 512, stream data width; only 512 is legal (elaboration error otherwise).
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width; must satisfy KEEP_WIDTH*8 == DATA_WIDTH.
- USER_WIDTH, 1, tuser width, passed through unchanged.
- OFFSET_WIDTH, 16, width of the byte-offset config; beat index = offset[OFFSET_WIDTH-1:6], lane = offset[5:0].
- STAT_WIDTH, 32, width of statistics counters.

Ports:
- clk  in  1  stream and config clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_enable  in  1  patch enable; sampled at frame start.
- cfg_offset  in  OFFSET_WIDTH  absolute byte offset of patch within frame.
- cfg_data  in  8  replacement byte.
- s_axis_tdata/tkeep/tvalid/tready/tlast/tuser  in/in/in/out/in/in  DATA_WIDTH/KEEP_WIDTH/1/1/1/USER_WIDTH  input stream.
- m_axis_tdata/tkeep/tvalid/tready/tlast/tuser  out/out/out/in/out/out  same widths  output stream.
- stat_frames  out  STAT_WIDTH  frames completed (tlast accepted on input).
- stat_patched  out  STAT_WIDTH  frames in which the patch byte was written.
- stat_short  out  STAT_WIDTH  enabled frames that ended before the patch offset.

Behaviour:
- Reset (async assert, released synchronously to clk):
  - m_axis_tvalid=0, s_axis_tready=0 while rst is high, and 1 on the first cycle after release.
  - All counters, beat counter, shadow config and FSM state return to 0/IDLE.
  - Reset mid-frame discards any buffered beats; no partial frame is emitted.
- FSM has two states.
  - IDLE: awaiting the first beat. On an accepted beat (tvalid&&tready), latch cfg_enable/cfg_offset/cfg_data into shadow registers; beat_idx=0. If tlast, stay IDLE, else go to FRAME.
  - FRAME: each accepted beat increments beat_idx. It saturates at all-ones and never wraps, so a patch cannot recur in giant frames. An accepted beat with tlast returns to IDLE.
- Patch condition on an accepted beat: shadow_en && beat_idx==shadow_offset[hi:6] && tkeep[shadow_offset[5:0]].
  - Output lane shadow_offset[5:0] = shadow_data; all other bytes pass unchanged. tkeep/tlast/tuser pass unchanged.
  - Bytes with tkeep=0 pass unchanged; no zeroing is done here.
- Statistics (all wrap modulo 2^STAT_WIDTH):
  - stat_patched increments once per patched frame, on the patched beat.
  - stat_short increments on tlast if shadow_en and the patch lane was not reached. This covers tlast with beat_idx < target, or beat_idx==target with tkeep[lane]=0. The frame passes unmodified.
  - stat_frames increments on every input tlast.
  - A single-beat frame can increment stat_frames and stat_patched/stat_short in the same cycle.
- Pipeline and handshake:
  - Latency is 1 cycle from input acceptance to m_axis_tvalid.
  - Output register plus one-entry skid buffer. s_axis_tready = !skid_valid (registered). Sustained 1 beat/cycle when m_axis_tready=1.
  - When m_axis_tready drops, at most one extra beat is captured in the skid buffer. Ordering is preserved and no beat is lost or duplicated.
  - m_axis_* must stay stable while tvalid && !tready.
- Config changes mid-frame have no effect until the next frame start. A change in the same cycle as first-beat acceptance is used for that frame.
- Offset beyond saturated beat range: never patched; counts as short at tlast.

Optional Feature:
- Macro KG_FRAME_PATCH_MASK_EN.
- Defined: adds port cfg_mask in 8, sampled and shadowed with the other config. The patched byte becomes (in & ~mask) | (data & mask). A mask of 0 still counts as patched.
- Undefined: the port is absent; full byte replacement (equivalent to mask=8'hff).

Test Plan:
- 3-beat frame, offset=70 (beat 1, lane 6), data=8'h5a, enable=1, m_tready=1 -> beat1 byte6=8'h5a, all else identical, latency 1, stat_patched=1, stat_frames=1.
- 1-beat frame tkeep=64'h0000_0000_0000_ffff, offset=20 -> unmodified, stat_short=1, stat_patched=0.
- Change cfg_data 8'h11->8'h22 during beat 1 of a 4-beat frame with offset=200 -> beat 3 lane 8 =8'h11; next frame uses 8'h22.
- Random m_tready (50%) over 100 back-to-back frames -> output equals model bitwise; no beat lost or duplicated; tvalid/tdata stable while stalled.
- Assert rst mid-frame with the skid buffer full -> m_axis_tvalid=0 immediately; counters 0; next frame after release handled correctly.
- With KG_FRAME_PATCH_MASK_EN, input byte 8'hf0, data 8'h0f, mask 8'h3c -> output byte 8'hcc.
